// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types and constants for the SPI memory port arbiter.
// Imported by the arbiter top and its round-robin picker.
package spi_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] RDATA_ABORT = 32'hFFFF_FFFF;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester and SPI-controller valid/ready bus of the memory arbiter.
// master = arbiter side, slave = requesters plus controller.
interface spi_mem_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*24-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_mem_select;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        req_rdata;
  logic               spi_valid;
  logic [23:0]        spi_addr;
  logic [31:0]        spi_wdata;
  logic               spi_we;
  logic               spi_mem_select;
  logic [31:0]        spi_rdata;
  logic               spi_ready;
  logic               timeout_err;
  logic               err_clr;

  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_mem_select,
    input  spi_rdata, spi_ready, err_clr,
    output req_ready, req_rdata,
    output spi_valid, spi_addr, spi_wdata, spi_we, spi_mem_select,
    output timeout_err
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_mem_select,
    output spi_rdata, spi_ready, err_clr,
    input  req_ready, req_rdata,
    input  spi_valid, spi_addr, spi_wdata, spi_we, spi_mem_select,
    input  timeout_err
  );
endinterface

// File: rtl/spi_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module spi_mem_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            any
);

  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory controller between NREQ valid/ready requesters:
// round-robin grant, one transaction in flight, watchdog abort on a stuck controller.
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT);

  arb_state_t    state, state_nxt;
  logic [PW-1:0] rr_ptr, grant, grant_q;
  logic          any;
  logic [WW-1:0] wdog;
  logic          done, abort;
  logic          err_q;
  logic [23:0]   addr_q, addr_sel;
  logic [31:0]   wdata_q, wdata_sel;
  logic          we_q, we_sel, sel_q, sel_sel;

  spi_mem_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any)
  );

  // A real completion wins over a watchdog expiry in the same cycle.
  always_comb begin
    done  = 1'b0;
    abort = 1'b0;
    if (state == ST_BUSY && rst_n) begin
      if (bus.spi_ready)         done  = 1'b1;
      else if (wdog == WDOG_MAX) abort = 1'b1;
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    sel_sel   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant == PW'(j)) begin
        addr_sel  = bus.req_addr[24*j +: 24];
        wdata_sel = bus.req_wdata[32*j +: 32];
        we_sel    = bus.req_we[j];
        sel_sel   = bus.req_mem_select[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any)           state_nxt = ST_BUSY;
      ST_BUSY: if (done || abort) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.req_rdata = '0;
    bus.spi_valid = (state == ST_BUSY);
    for (int j = 0; j < NREQ; j++) begin
      if (grant_q == PW'(j)) bus.req_ready[j] = done || abort;
    end
    if (done)       bus.req_rdata = bus.spi_rdata;
    else if (abort) bus.req_rdata = RDATA_ABORT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      wdog    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && any) begin
        grant_q <= grant;
        rr_ptr  <= PW'(next_idx(int'(grant), NREQ));
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
        we_q    <= we_sel;
        sel_q   <= sel_sel;
        wdog    <= '0;
      end else if (state == ST_BUSY && !done && !abort) begin
        wdog <= wdog + 1'b1;
      end
      if (abort)            err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.spi_addr       = addr_q;
  assign bus.spi_wdata      = wdata_q;
  assign bus.spi_we         = we_q;
  assign bus.spi_mem_select = sel_q;
  assign bus.timeout_err    = err_q;

endmodule
